// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: per-loop start/end/counter storage, PC-based loop
// selection with index-0 priority, counter decrement and a CSR read port.
module riscv_hwloop_regs #(
    parameter int N_LOOPS    = 2,
    parameter int LOOP_IDX_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             current_pc_i,
    input  logic [2:0]              hwlp_we_i,
    input  logic [LOOP_IDX_W-1:0]   hwlp_regid_i,
    input  logic [31:0]             hwlp_start_data_i,
    input  logic [31:0]             hwlp_end_data_i,
    input  logic [31:0]             hwlp_cnt_data_i,
    input  logic                    hwlp_clear_i,
    input  logic                    hwlp_dec_cnt_i,
    output logic [31:0]             hwlp_start_addr_o,
    output logic [31:0]             hwlp_end_addr_o,
    output logic [31:0]             hwlp_counter_o,
    output logic                    hwlp_sel_valid_o,
    input  logic [LOOP_IDX_W+1:0]   hwlp_raddr_i,
    output logic [31:0]             hwlp_rdata_o,
    output logic [N_LOOPS-1:0]      hwlp_valid_o
);

    logic [31:0]            start_q [N_LOOPS];
    logic [31:0]            end_q   [N_LOOPS];
    logic [31:0]            cnt_q   [N_LOOPS];
    logic [N_LOOPS-1:0]     valid_q;

    logic [LOOP_IDX_W-1:0]  sel;
    logic                   sel_valid;
    logic [LOOP_IDX_W-1:0]  rd_idx;
    logic [1:0]             rd_field;

    // Lowest matching index wins; with no match the loop-0 addresses are shown
    // but the counter is forced to zero so the controller never jumps.
    always_comb begin
        sel               = '0;
        sel_valid         = 1'b0;
        hwlp_start_addr_o = start_q[0];
        hwlp_end_addr_o   = end_q[0];
        hwlp_counter_o    = '0;
        for (int unsigned i = 0; i < N_LOOPS; i++) begin
            if (!sel_valid && valid_q[i] && (end_q[i] == current_pc_i)) begin
                sel               = LOOP_IDX_W'(i);
                sel_valid         = 1'b1;
                hwlp_start_addr_o = start_q[i];
                hwlp_end_addr_o   = end_q[i];
                hwlp_counter_o    = cnt_q[i];
            end
        end
    end

    assign hwlp_sel_valid_o = sel_valid;
    assign hwlp_valid_o     = valid_q;

    // Clear blocks counter writes and decrements so valid cannot be re-set in
    // the flush cycle; start/end writes never touch valid and still apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < N_LOOPS; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_LOOPS; i++) begin
                if (hwlp_regid_i == LOOP_IDX_W'(i)) begin
                    if (hwlp_we_i[0]) start_q[i] <= hwlp_start_data_i;
                    if (hwlp_we_i[1]) end_q[i]   <= hwlp_end_data_i;
                end
                if (hwlp_clear_i) begin
                    valid_q[i] <= 1'b0;
                end else if (hwlp_we_i[2] && (hwlp_regid_i == LOOP_IDX_W'(i))) begin
                    cnt_q[i]   <= hwlp_cnt_data_i;
                    valid_q[i] <= (hwlp_cnt_data_i != '0);
                end else if (hwlp_dec_cnt_i && sel_valid && (sel == LOOP_IDX_W'(i))) begin
                    cnt_q[i]   <= cnt_q[i] - 32'd1;
                    valid_q[i] <= (cnt_q[i] != 32'd1);
                end
            end
        end
    end

    assign rd_idx   = hwlp_raddr_i[LOOP_IDX_W+1:2];
    assign rd_field = hwlp_raddr_i[1:0];

    always_comb begin
        hwlp_rdata_o = '0;
        if (rd_field == 2'd3) begin
            hwlp_rdata_o = 32'(valid_q);
        end else begin
            for (int unsigned i = 0; i < N_LOOPS; i++) begin
                if (rd_idx == LOOP_IDX_W'(i)) begin
                    case (rd_field)
                        2'd0:    hwlp_rdata_o = start_q[i];
                        2'd1:    hwlp_rdata_o = end_q[i];
                        default: hwlp_rdata_o = cnt_q[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed self-checking bench for riscv_hwloop_regs (N_LOOPS = 2).
module tb_riscv_hwloop_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] current_pc_i;
    logic [2:0]  hwlp_we_i;
    logic [0:0]  hwlp_regid_i;
    logic [31:0] hwlp_start_data_i;
    logic [31:0] hwlp_end_data_i;
    logic [31:0] hwlp_cnt_data_i;
    logic        hwlp_clear_i;
    logic        hwlp_dec_cnt_i;
    logic [31:0] hwlp_start_addr_o;
    logic [31:0] hwlp_end_addr_o;
    logic [31:0] hwlp_counter_o;
    logic        hwlp_sel_valid_o;
    logic [2:0]  hwlp_raddr_i;
    logic [31:0] hwlp_rdata_o;
    logic [1:0]  hwlp_valid_o;

    int checks = 0;
    int errors = 0;

    riscv_hwloop_regs #(.N_LOOPS(2), .LOOP_IDX_W(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .current_pc_i      (current_pc_i),
        .hwlp_we_i         (hwlp_we_i),
        .hwlp_regid_i      (hwlp_regid_i),
        .hwlp_start_data_i (hwlp_start_data_i),
        .hwlp_end_data_i   (hwlp_end_data_i),
        .hwlp_cnt_data_i   (hwlp_cnt_data_i),
        .hwlp_clear_i      (hwlp_clear_i),
        .hwlp_dec_cnt_i    (hwlp_dec_cnt_i),
        .hwlp_start_addr_o (hwlp_start_addr_o),
        .hwlp_end_addr_o   (hwlp_end_addr_o),
        .hwlp_counter_o    (hwlp_counter_o),
        .hwlp_sel_valid_o  (hwlp_sel_valid_o),
        .hwlp_raddr_i      (hwlp_raddr_i),
        .hwlp_rdata_o      (hwlp_rdata_o),
        .hwlp_valid_o      (hwlp_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic idx, input logic [2:0] we,
                      input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        hwlp_regid_i      = idx;
        hwlp_we_i         = we;
        hwlp_start_data_i = s;
        hwlp_end_data_i   = e;
        hwlp_cnt_data_i   = c;
        tick();
        hwlp_we_i         = 3'b000;
    endtask

    task automatic csr(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        hwlp_raddr_i = addr;
        #1;
        check(tag, hwlp_rdata_o, exp);
    endtask

    initial begin
        rst_n             = 1'b0;
        current_pc_i      = '0;
        hwlp_we_i         = '0;
        hwlp_regid_i      = '0;
        hwlp_start_data_i = '0;
        hwlp_end_data_i   = '0;
        hwlp_cnt_data_i   = '0;
        hwlp_clear_i      = 1'b0;
        hwlp_dec_cnt_i    = 1'b0;
        hwlp_raddr_i      = '0;
        #12;
        check("rst_valid",     32'(hwlp_valid_o), 32'h0);
        check("rst_counter",   hwlp_counter_o, 32'h0);
        check("rst_sel_valid", 32'(hwlp_sel_valid_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic write and selection
        wr(1'b0, 3'b111, 32'h100, 32'h120, 32'd3);
        check("wr_valid", 32'(hwlp_valid_o), 32'h1);
        current_pc_i = 32'h120;
        #1;
        check("sel_start",   hwlp_start_addr_o, 32'h100);
        check("sel_end",     hwlp_end_addr_o, 32'h120);
        check("sel_counter", hwlp_counter_o, 32'd3);
        check("sel_valid",   32'(hwlp_sel_valid_o), 32'h1);
        current_pc_i = 32'h124;
        #1;
        check("nomatch_sel",     32'(hwlp_sel_valid_o), 32'h0);
        check("nomatch_counter", hwlp_counter_o, 32'h0);
        check("nomatch_start",   hwlp_start_addr_o, 32'h100);

        // Decrement down to zero
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd2);
        current_pc_i   = 32'h120;
        hwlp_dec_cnt_i = 1'b1;
        tick();
        check("dec1_counter", hwlp_counter_o, 32'd1);
        check("dec1_valid",   32'(hwlp_valid_o), 32'h1);
        tick();
        hwlp_dec_cnt_i = 1'b0;
        #1;
        check("dec2_valid",     32'(hwlp_valid_o), 32'h0);
        check("dec2_sel_valid", 32'(hwlp_sel_valid_o), 32'h0);
        check("dec2_counter",   hwlp_counter_o, 32'h0);
        csr("dec2_csr_cnt0", 3'b010, 32'h0);

        // Nested loops sharing an end address
        wr(1'b0, 3'b111, 32'h100, 32'h140, 32'd2);
        wr(1'b1, 3'b111, 32'h080, 32'h140, 32'd4);
        current_pc_i = 32'h140;
        #1;
        check("nest_valid",   32'(hwlp_valid_o), 32'h3);
        check("nest_start",   hwlp_start_addr_o, 32'h100);
        check("nest_counter", hwlp_counter_o, 32'd2);
        hwlp_dec_cnt_i = 1'b1;
        tick();
        hwlp_dec_cnt_i = 1'b0;
        check("nest_dec_cnt0", hwlp_counter_o, 32'd1);
        csr("nest_csr_cnt1", 3'b110, 32'd4);
        hwlp_dec_cnt_i = 1'b1;
        tick();
        hwlp_dec_cnt_i = 1'b0;
        #1;
        check("inner_done_valid", 32'(hwlp_valid_o), 32'h2);
        check("outer_sel_valid",  32'(hwlp_sel_valid_o), 32'h1);
        check("outer_start",      hwlp_start_addr_o, 32'h080);
        check("outer_counter",    hwlp_counter_o, 32'd4);

        // Counter write beats a same-cycle decrement
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd7);
        check("pre_wd_counter", hwlp_counter_o, 32'd7);
        hwlp_dec_cnt_i = 1'b1;
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd5);
        hwlp_dec_cnt_i = 1'b0;
        csr("wd_csr_cnt0", 3'b010, 32'd5);
        check("wd_valid",   32'(hwlp_valid_o), 32'h3);
        check("wd_counter", hwlp_counter_o, 32'd5);
        csr("wd_csr_cnt1", 3'b110, 32'd4);

        // Clear invalidates, counters retained
        hwlp_clear_i = 1'b1;
        tick();
        hwlp_clear_i = 1'b0;
        check("clr_valid",     32'(hwlp_valid_o), 32'h0);
        check("clr_sel_valid", 32'(hwlp_sel_valid_o), 32'h0);
        csr("clr_csr_cnt1",  3'b110, 32'd4);
        csr("clr_csr_end0",  3'b001, 32'h140);
        wr(1'b1, 3'b100, 32'h0, 32'h0, 32'd0);
        check("zero_wr_valid", 32'(hwlp_valid_o), 32'h0);
        csr("zero_wr_csr_valid", 3'b111, 32'h0);

        // Asynchronous reset in the middle of a decrement run
        wr(1'b0, 3'b100, 32'h0, 32'h0, 32'd3);
        csr("pre_ar_csr_valid", 3'b011, 32'h1);
        hwlp_dec_cnt_i = 1'b1;
        tick();
        check("pre_ar_counter", hwlp_counter_o, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_counter",   hwlp_counter_o, 32'h0);
        check("ar_sel_valid", 32'(hwlp_sel_valid_o), 32'h0);
        check("ar_valid",     32'(hwlp_valid_o), 32'h0);
        check("ar_start",     hwlp_start_addr_o, 32'h0);
        check("ar_end",       hwlp_end_addr_o, 32'h0);
        csr("ar_csr_cnt0", 3'b010, 32'h0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        hwlp_dec_cnt_i = 1'b0;
        check("post_ar_valid", 32'(hwlp_valid_o), 32'h0);
        csr("post_ar_csr_cnt0", 3'b010, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
